// File: rtl/data_mem_ctl_pkg.sv
// Shared types for the data memory controller.
package data_mem_ctl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ctl_if.sv
// Request/response bus between a requester and data_mem_ctl.
interface data_mem_ctl_if #(
  parameter int W = 8,
  parameter int A = 8
) ();

  logic         ReqValid;
  logic         ReqWrite;
  logic [A-1:0] Addr;
  logic [W-1:0] DataIn;
  logic         Ready;
  logic         Busy;
  logic         RspValid;
  logic [W-1:0] DataOut;
  logic [W-1:0] MonOut;

  modport master (
    output ReqValid, ReqWrite, Addr, DataIn,
    input  Ready, Busy, RspValid, DataOut, MonOut
  );

  modport slave (
    input  ReqValid, ReqWrite, Addr, DataIn,
    output Ready, Busy, RspValid, DataOut, MonOut
  );

endinterface

// File: rtl/data_mem_ctl.sv
// Single-port data memory with a post-reset zero-fill sequence and a
// registered 1-cycle read path; MonOut exposes one fixed word combinationally.
module data_mem_ctl
  import data_mem_ctl_pkg::*;
#(
  parameter int W            = 8,
  parameter int A            = 8,
  parameter int MON_ADDR     = 64,
  parameter int CLR_ON_RESET = 1
) (
  input  logic           Clk,
  input  logic           Reset,
  data_mem_ctl_if.slave  bus
);

  localparam int          DEPTH = 2**A;
  localparam logic [A-1:0] MON  = A'(MON_ADDR);
  localparam logic        CLR   = (CLR_ON_RESET != 0);

  logic [W-1:0] Core [DEPTH];

  state_t       state;
  logic [A-1:0] ClrCnt;
  logic         ready_q;
  logic         busy_q;
  logic         rsp_q;
  logic [W-1:0] dout_q;

  logic         ready;
  logic         accept;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;

  // Reset overrides the registered flags in the same cycle it is asserted.
  assign ready  = ready_q && !Reset;
  assign accept = bus.ReqValid && ready;

  // Single write port shared by the clear sequence and accepted writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.Addr;
    wr_data = bus.DataIn;
    if (!Reset) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = ClrCnt;
        wr_data = '0;
      end else if (accept && bus.ReqWrite) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      Core[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLR ? CLEAR : RUN;
      ClrCnt  <= '0;
      rsp_q   <= 1'b0;
      dout_q  <= '0;
      ready_q <= !CLR;
      busy_q  <= CLR;
    end else begin
      rsp_q <= 1'b0;
      case (state)
        CLEAR: begin
          ClrCnt <= ClrCnt + 1'b1;
          // Counter wrap is the exit: the last word is written on this edge.
          if (ClrCnt == '1) begin
            state   <= RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (accept && !bus.ReqWrite) begin
            rsp_q  <= 1'b1;
            dout_q <= Core[bus.Addr];
          end
        end
        default: state <= CLR ? CLEAR : RUN;
      endcase
    end
  end

  assign bus.Ready    = ready;
  assign bus.Busy     = Reset ? CLR : busy_q;
  assign bus.RspValid = rsp_q;
  assign bus.DataOut  = dout_q;
  assign bus.MonOut   = Core[MON];

endmodule

// File: tb/tb_data_mem_ctl.sv
// Self-checking bench for data_mem_ctl: clear timing, read/write semantics,
// monitor port, reset interactions and the no-clear variant.
module tb_data_mem_ctl;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  data_mem_ctl_if #(.W(8), .A(4)) b0 ();
  data_mem_ctl_if #(.W(8), .A(4)) b1 ();

  data_mem_ctl #(.W(8), .A(4), .MON_ADDR(5), .CLR_ON_RESET(1)) u0 (
    .Clk(clk), .Reset(rst0), .bus(b0)
  );

  data_mem_ctl #(.W(8), .A(4), .MON_ADDR(5), .CLR_ON_RESET(0)) u1 (
    .Clk(clk), .Reset(rst1), .bus(b1)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [7:0] mem_m [16];
  logic [7:0] last_rd;
  logic       busy1_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst1 && b1.Busy === 1'b1) busy1_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    b0.ReqValid = 1'b1;
    b0.ReqWrite = 1'b1;
    b0.Addr     = 4'(a);
    b0.DataIn   = d;
    tick();
    b0.ReqValid = 1'b0;
    mem_m[a] = d;
    chk("wr_rspvalid", 32'(b0.RspValid), 32'd0);
    chk("wr_dout_hold", 32'(b0.DataOut), 32'(last_rd));
    chk("wr_monout", 32'(b0.MonOut), 32'(mem_m[5]));
  endtask

  task automatic rd(input int a);
    b0.ReqValid = 1'b1;
    b0.ReqWrite = 1'b0;
    b0.Addr     = 4'(a);
    tick();
    b0.ReqValid = 1'b0;
    last_rd = mem_m[a];
    chk("rd_rspvalid", 32'(b0.RspValid), 32'd1);
    chk("rd_data", 32'(b0.DataOut), 32'(last_rd));
    chk("rd_monout", 32'(b0.MonOut), 32'(mem_m[5]));
  endtask

  // Counts Busy cycles after reset release; any request left on the bus is
  // held during the fill and must produce no response.
  task automatic clear_wait();
    int   n;
    logic saw_rsp;
    n       = 0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 40 && b0.Busy === 1'b1; i++) begin
      if (b0.Ready !== 1'b0) saw_rsp = 1'b1;
      n++;
      tick();
      if (b0.RspValid !== 1'b0) saw_rsp = 1'b1;
    end
    b0.ReqValid = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd16);
    chk("clear_no_rsp_or_ready", 32'(saw_rsp), 32'd0);
    chk("clear_ready", 32'(b0.Ready), 32'd1);
    chk("clear_monout", 32'(b0.MonOut), 32'd0);
    for (int k = 0; k < 16; k++) mem_m[k] = 8'h00;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.ReqValid = 1'b0; b0.ReqWrite = 1'b0; b0.Addr = '0; b0.DataIn = '0;
    b1.ReqValid = 1'b0; b1.ReqWrite = 1'b0; b1.Addr = '0; b1.DataIn = '0;
    last_rd = 8'h00;
    for (int k = 0; k < 16; k++) mem_m[k] = 8'h00;

    tick();
    chk("rst_ready", 32'(b0.Ready), 32'd0);
    chk("rst_busy", 32'(b0.Busy), 32'd1);
    chk("rst_rspvalid", 32'(b0.RspValid), 32'd0);
    chk("rst_dout", 32'(b0.DataOut), 32'd0);
    chk("rst1_ready", 32'(b1.Ready), 32'd0);
    chk("rst1_busy", 32'(b1.Busy), 32'd0);

    // Release with a read pending: it must be ignored until the fill ends.
    rst0 = 1'b0;
    b0.ReqValid = 1'b1;
    b0.ReqWrite = 1'b0;
    b0.Addr     = 4'd3;
    clear_wait();

    for (int a = 0; a < 16; a++) rd(a);

    wr(3, 8'hA5);
    rd(3);

    wr(5, 8'h3C);
    chk("mon_after_wr5", 32'(b0.MonOut), 32'h3C);
    wr(6, 8'h11);
    chk("mon_after_wr6", 32'(b0.MonOut), 32'h3C);

    for (int i = 0; i < 80; i++) begin
      int unsigned a;
      a = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) wr(int'(a), 8'($urandom_range(0, 255)));
      else rd(int'(a));
    end

    // Reset mid-fill restarts the fill from word 0.
    wr(15, 8'hFF);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    repeat (8) tick();
    chk("midclear_busy", 32'(b0.Busy), 32'd1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    clear_wait();
    rd(15);

    // Reset in the cycle the read response is presented discards it.
    wr(2, 8'h5A);
    b0.ReqValid = 1'b1;
    b0.ReqWrite = 1'b0;
    b0.Addr     = 4'd2;
    tick();
    b0.ReqValid = 1'b0;
    rst0 = 1'b1;
    chk("pre_rst_rspvalid", 32'(b0.RspValid), 32'd1);
    chk("pre_rst_dout", 32'(b0.DataOut), 32'h5A);
    tick();
    chk("post_rst_rspvalid", 32'(b0.RspValid), 32'd0);
    chk("post_rst_dout", 32'(b0.DataOut), 32'd0);
    rst0 = 1'b0;
    clear_wait();
    last_rd = 8'h00;
    rd(0);

    // Variant without the zero fill.
    rst1 = 1'b0;
    tick();
    chk("nc_ready", 32'(b1.Ready), 32'd1);
    chk("nc_busy", 32'(b1.Busy), 32'd0);
    b1.ReqValid = 1'b1;
    b1.ReqWrite = 1'b1;
    b1.Addr     = 4'd0;
    b1.DataIn   = 8'h7E;
    tick();
    chk("nc_wr_rspvalid", 32'(b1.RspValid), 32'd0);
    b1.ReqWrite = 1'b0;
    tick();
    b1.ReqValid = 1'b0;
    chk("nc_rd_rspvalid", 32'(b1.RspValid), 32'd1);
    chk("nc_rd_data", 32'(b1.DataOut), 32'h7E);
    tick();
    chk("nc_idle_rspvalid", 32'(b1.RspValid), 32'd0);
    chk("nc_dout_hold", 32'(b1.DataOut), 32'h7E);
    chk("nc_busy_never", 32'(busy1_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctl.md
DATA_MEM_CTL -- requirements
Module: data_mem_ctl

Interface
REQ-001 Parameter W, default 8, data word width in bits.
REQ-002 Parameter A, default 8, address width; depth SHALL be 2**A words.
REQ-003 Parameter MON_ADDR, default 64, word address driven on MonOut; SHALL be < 2**A.
REQ-004 Parameter CLR_ON_RESET, default 1; 1 = zero-fill memory after reset, 0 = no fill.
REQ-005 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 ReqValid  input  1  request present this cycle.
REQ-008 ReqWrite  input  1  1 = write, 0 = read; qualified by ReqValid.
REQ-009 Addr  input  A  word address of request.
REQ-010 DataIn  input  W  write data.
REQ-011 Ready  output  1  block accepts a request this cycle.
REQ-012 Busy  output  1  clear sequence in progress.
REQ-013 RspValid  output  1  DataOut carries read data for the read accepted the previous cycle.
REQ-014 DataOut  output  W  registered read data.
REQ-015 MonOut  output  W  combinational view of Core[MON_ADDR].

Function
REQ-016 Storage SHALL be a single-port array of 2**A words of W bits; at most one access per cycle.
REQ-017 FSM SHALL have two states: CLEAR and RUN.
REQ-018 CLEAR: each cycle writes 0 to Core[ClrCnt], ClrCnt increments by 1; Busy=1, Ready=0.
REQ-019 CLEAR->RUN on the cycle ClrCnt == 2**A-1 (after writing that word); fill SHALL take exactly 2**A cycles.
REQ-020 ClrCnt SHALL be A+0 bits wide and SHALL NOT wrap back into CLEAR; wrap is the exit condition.
REQ-021 RUN: Ready=1, Busy=0; request accepted iff ReqValid && Ready.
REQ-022 Accepted write: Core[Addr] <= DataIn at that edge; RspValid SHALL NOT assert.
REQ-023 Accepted read: DataOut <= Core[Addr] and RspValid <= 1 at that edge (1-cycle latency).
REQ-024 RspValid SHALL be 0 in any cycle not following an accepted read; back-to-back reads give RspValid high every cycle.
REQ-025 DataOut SHALL hold its last read value until the next accepted read.
REQ-026 Write followed by read of same address next cycle SHALL return the new data.
REQ-027 MonOut SHALL reflect a write to MON_ADDR in the cycle after the write edge, and 0 after clear completes.
REQ-028 Requests presented while Ready=0 SHALL be ignored with no side effect.
REQ-029 If CLR_ON_RESET=0, CLEAR SHALL be skipped: state RUN from the first cycle after Reset deasserts; memory contents undefined until written.

Reset
REQ-030 While Reset=1: state <= CLEAR (or RUN if CLR_ON_RESET=0), ClrCnt <= 0, RspValid <= 0, DataOut <= 0; no memory write.
REQ-031 During Reset, Ready=0 and Busy = CLR_ON_RESET.
REQ-032 Reset asserted mid-CLEAR SHALL restart the fill from address 0.
REQ-033 Reset asserted the cycle after an accepted read SHALL force RspValid to 0; the response is discarded.
REQ-034 Memory array contents SHALL NOT be reset directly; only via CLEAR.

Structure
REQ-035 State enum (CLEAR, RUN) SHALL live in the shared processor package; W/A defaults stay module parameters.
REQ-036 No sub-module; array, FSM and clear counter SHALL be in data_mem_ctl.

Verification (W=8, A=4, MON_ADDR=5, CLR_ON_RESET=1 unless stated)
REQ-037 Reset 1 cycle, release -> Busy=1 for exactly 16 cycles, then Ready=1; reads of all 16 addresses return 0x00.
REQ-038 Write 0xA5 to addr 3, read addr 3 next cycle -> RspValid=1 and DataOut=0xA5 one cycle after read; RspValid=0 after write.
REQ-039 Write 0x3C to addr 5 -> MonOut=0x3C the following cycle; write 0x11 to addr 6 -> MonOut unchanged.
REQ-040 Reset pulsed at clear cycle 8 -> Busy stays high another 16 cycles after release; addr 15 pre-written 0xFF reads 0x00.
REQ-041 ReqValid=1 read during CLEAR -> no RspValid, no state change; Reset one cycle after accepted read -> RspValid=0, DataOut=0.
REQ-042 CLR_ON_RESET=0: release reset -> Ready=1 next cycle, Busy never asserts; write/read 0x7E at addr 0 round-trips.
